legv8_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between LEGv8 instruction fetch (I-port, read-only)
//  and data load/store (D-port, read/write). Sequences every access through a small FSM.

---
 rtl/legv8_mem_arbiter_pkg.sv | 20 ++
 rtl/legv8_mem_arbiter_if.sv | 36 +++
 rtl/legv8_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_legv8_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_mem_arbiter_pkg.sv
// Shared types and widths for the LEGv8 unified-memory arbiter.
// The owner type records which port won the current memory access.
package legv8_mem_pkg;

    localparam int DW     = 64;
    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/legv8_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter.
// slave = arbiter view, master = core/memory environment view.
interface legv8_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    import legv8_mem_pkg::*;

    logic              i_req;
    logic [DW-1:0]     i_addr;
    logic              i_ack;
    logic [INST_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [DW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic              d_ack;
    logic [DW-1:0]     d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW-1:0]     m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/legv8_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and
// data load/store: D has priority, I is forced after STARVE_MAX D grants.
module legv8_mem_arbiter
    import legv8_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    legv8_mem_arbiter_if.slave bus
);

    localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    arb_state_t          state_reg;
    owner_t              owner_reg;
    logic                we_reg;
    logic                sel_hi_reg;
    logic [CNT_W-1:0]    lat_cnt_reg;
    logic [STARVE_W-1:0] starve_reg;

    logic              i_ack_reg;
    logic              d_ack_reg;
    logic [INST_W-1:0] i_rdata_reg;
    logic [DW-1:0]     d_rdata_reg;
    logic              m_en_reg;
    logic              m_we_reg;
    logic [ADDR_W-1:0] m_addr_reg;
    logic [DW-1:0]     m_wdata_reg;

    logic force_i;
    assign force_i = bus.i_req && (starve_reg == STARVE_TOP);

    // Address bits outside the word index are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[DW-1:ADDR_W+3], bus.i_addr[1:0],
                                bus.d_addr[DW-1:ADDR_W+3], bus.d_addr[2:0]};

    // Memory strobes are registered on the IDLE grant so m_en is high exactly
    // while the FSM sits in ISSUE; likewise acks are set on the WAIT exit so
    // they are high exactly during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_I;
            we_reg      <= 1'b0;
            sel_hi_reg  <= 1'b0;
            lat_cnt_reg <= '0;
            starve_reg  <= '0;
            i_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
            m_en_reg    <= 1'b0;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
        end else begin
            i_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;
            m_en_reg  <= 1'b0;
            m_we_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.d_req && !force_i) begin
                        owner_reg   <= OWN_D;
                        we_reg      <= bus.d_we;
                        m_en_reg    <= 1'b1;
                        m_we_reg    <= bus.d_we;
                        m_addr_reg  <= bus.d_addr[ADDR_W+2:3];
                        m_wdata_reg <= bus.d_wdata;
                        state_reg   <= ISSUE;
                        if (!bus.i_req)
                            starve_reg <= '0;
                        else if (starve_reg != STARVE_TOP)
                            starve_reg <= starve_reg + 1'b1;
                    end else if (bus.i_req) begin
                        owner_reg   <= OWN_I;
                        we_reg      <= 1'b0;
                        sel_hi_reg  <= bus.i_addr[2];
                        m_en_reg    <= 1'b1;
                        m_addr_reg  <= bus.i_addr[ADDR_W+2:3];
                        starve_reg  <= '0;
                        state_reg   <= ISSUE;
                    end else begin
                        starve_reg <= '0;
                    end
                end
                ISSUE: begin
                    lat_cnt_reg <= LAT_LOAD;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt_reg == '0) begin
                        if (owner_reg == OWN_I) begin
                            i_rdata_reg <= sel_hi_reg ? bus.m_rdata[63:32]
                                                      : bus.m_rdata[31:0];
                            i_ack_reg   <= 1'b1;
                        end else begin
                            if (!we_reg)
                                d_rdata_reg <= bus.m_rdata;
                            d_ack_reg <= 1'b1;
                        end
                        state_reg <= RESP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack   = i_ack_reg;
    assign bus.i_rdata = i_rdata_reg;
    assign bus.d_ack   = d_ack_reg;
    assign bus.d_rdata = d_rdata_reg;
    assign bus.m_en    = m_en_reg;
    assign bus.m_we    = m_we_reg;
    assign bus.m_addr  = m_addr_reg;
    assign bus.m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
// Scoreboard bench for legv8_mem_arbiter: directed requests push expected memory
// strobes and acks; a monitor thread pops and compares as the DUT produces them.
module tb_legv8_mem_arbiter;

    localparam int ADDR_W  = 10;
    localparam int MEM_LAT = 2;

    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    legv8_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    legv8_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(2)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Memory model: data appears exactly MEM_LAT cycles after m_en, garbage otherwise.
    logic [63:0]       mem [0:(1<<ADDR_W)-1];
    logic [63:0]       rd_pipe [0:MEM_LAT-1];
    logic              bd_en   = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [63:0]       bd_data = '0;

    always @(posedge tb_clk) begin
        if (bd_en)
            mem[bd_addr] <= bd_data;
        else if (bus.m_en && bus.m_we)
            mem[bus.m_addr] <= bus.m_wdata;
        rd_pipe[0] <= bus.m_en ? mem[bus.m_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 1; k < MEM_LAT; k++)
            rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.m_rdata = rd_pipe[MEM_LAT-1];

    typedef struct {
        int          cyc;
        bit          we;
        logic [9:0]  addr;
        logic [63:0] wdata;
    } men_exp_t;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
        int          cyc;
    } ack_exp_t;

    men_exp_t men_q[$];
    ack_exp_t ack_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_men(input int c, input bit we, input logic [9:0] a, input logic [63:0] wd);
        men_exp_t e;
        e.cyc = c; e.we = we; e.addr = a; e.wdata = wd;
        men_q.push_back(e);
    endtask

    task automatic push_ack(input bit is_d, input logic [63:0] data, input int c);
        ack_exp_t e;
        e.is_d = is_d; e.data = data; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic monitor();
        men_exp_t m;
        ack_exp_t a;
        forever begin
            @(negedge tb_clk);
            if (!rst) begin
                if (bus.m_en) begin
                    if (men_q.size() == 0) begin
                        chk("spurious_m_en", 64'(bus.m_en), 64'd0);
                    end else begin
                        m = men_q.pop_front();
                        chk("m_en_cycle", 64'(cyc), 64'(m.cyc));
                        chk("m_we", 64'(bus.m_we), 64'(m.we));
                        chk("m_addr", 64'(bus.m_addr), 64'(m.addr));
                        if (m.we) chk("m_wdata", bus.m_wdata, m.wdata);
                    end
                end
                if (bus.m_we && !bus.m_en)
                    chk("m_we_without_m_en", 64'(bus.m_we), 64'd0);
                if (bus.i_ack && bus.d_ack)
                    chk("dual_ack", 64'(bus.i_ack & bus.d_ack), 64'd0);
                if (bus.i_ack || bus.d_ack) begin
                    if (ack_q.size() == 0) begin
                        chk("spurious_ack", 64'(bus.i_ack | bus.d_ack), 64'd0);
                    end else begin
                        a = ack_q.pop_front();
                        chk("ack_owner_is_d", 64'(bus.d_ack), 64'(a.is_d));
                        chk("ack_cycle", 64'(cyc), 64'(a.cyc));
                        if (a.is_d) chk("d_rdata", bus.d_rdata, a.data);
                        else        chk("i_rdata", 64'(bus.i_rdata), a.data);
                        $display("txn %s ack at cycle %0d i_rdata=%h d_rdata=%h",
                                 bus.d_ack ? "D" : "I", cyc, bus.i_rdata, bus.d_rdata);
                    end
                end
            end
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(posedge tb_clk); #1;
        bd_en = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_i_ack",   64'(bus.i_ack),   64'd0);
        chk("rst_d_ack",   64'(bus.d_ack),   64'd0);
        chk("rst_m_en",    64'(bus.m_en),    64'd0);
        chk("rst_m_we",    64'(bus.m_we),    64'd0);
        chk("rst_i_rdata", 64'(bus.i_rdata), 64'd0);
        chk("rst_d_rdata", bus.d_rdata,      64'd0);
        chk("rst_m_addr",  64'(bus.m_addr),  64'd0);
        chk("rst_m_wdata", bus.m_wdata,      64'd0);
    endtask

    // Hold i_req for n acks, then drop it on the edge ending the last ack cycle.
    task automatic run_i(input logic [63:0] addr, input int n);
        bit got;
        bus.i_addr = addr;
        bus.i_req  = 1'b1;
        for (int t = 0; t < n; t++) begin
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge tb_clk);
                got = bus.i_ack;
            end
            if (!got) chk("i_ack_timeout", 64'(got), 64'd1);
            @(posedge tb_clk); #1;
        end
        bus.i_req = 1'b0;
    endtask

    // Same for D; the address switches to addr_b after each ack while req stays up.
    task automatic run_d(input bit we, input logic [63:0] addr, input logic [63:0] addr_b,
                         input logic [63:0] wdata, input int n);
        bit got;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        for (int t = 0; t < n; t++) begin
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge tb_clk);
                got = bus.d_ack;
            end
            if (!got) chk("d_ack_timeout", 64'(got), 64'd1);
            @(posedge tb_clk); #1;
            bus.d_addr = addr_b;
        end
        bus.d_req = 1'b0;
    endtask

    int base;

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        fork
            monitor();
        join_none

        preload(10'h020, 64'hAAAABBBB_CCCCDDDD);
        preload(10'h021, 64'h12345678_9ABCDEF0);
        preload(10'h030, 64'h55556666_77778888);
        preload(10'h060, 64'hD0D0D0D0_E1E1E1E1);
        preload(10'h001, 64'h01010101_01010101);
        preload(10'h002, 64'h02020202_02020202);

        // 1: release reset mid-cycle, everything idle and zero
        @(posedge tb_clk); #3;
        rst = 1'b0;
        @(negedge tb_clk);
        reset_checks();
        repeat (3) @(posedge tb_clk);
        #1;

        // 5: reset during WAIT of a D load -> no ack, d_rdata stays 0
        base = cyc;
        push_men(base + 1, 1'b0, 10'h030, 64'd0);
        bus.d_we = 1'b0; bus.d_addr = 64'h180; bus.d_req = 1'b1;
        @(posedge tb_clk); #1;
        @(posedge tb_clk); #1;
        rst = 1'b1;
        bus.d_req = 1'b0;
        @(posedge tb_clk); #3;
        rst = 1'b0;
        @(negedge tb_clk);
        reset_checks();
        repeat (4) @(posedge tb_clk);
        #1;
        base = cyc;
        push_men(base + 1, 1'b0, 10'h020, 64'd0);
        push_ack(1'b0, 64'h00000000_CCCCDDDD, base + 4);
        run_i(64'h100, 1);
        chk("i_period", 64'(cyc - base), 64'd5);

        // 2: fetch upper instruction word
        base = cyc;
        push_men(base + 1, 1'b0, 10'h020, 64'd0);
        push_ack(1'b0, 64'h00000000_AAAABBBB, base + 4);
        run_i(64'h104, 1);

        // 3: store then load back (store leaves d_rdata at 0)
        base = cyc;
        push_men(base + 1, 1'b1, 10'h040, 64'h11223344_55667788);
        push_ack(1'b1, 64'd0, base + 4);
        run_d(1'b1, 64'h200, 64'h200, 64'h11223344_55667788, 1);
        base = cyc;
        push_men(base + 1, 1'b0, 10'h040, 64'd0);
        push_ack(1'b1, 64'h11223344_55667788, base + 4);
        run_d(1'b0, 64'h200, 64'h200, 64'd0, 1);

        // 4: both ports held -> D,D,I,D,D,I every 5 cycles
        base = cyc;
        push_men(base + 1,  1'b0, 10'h060, 64'd0);
        push_men(base + 6,  1'b0, 10'h060, 64'd0);
        push_men(base + 11, 1'b0, 10'h021, 64'd0);
        push_men(base + 16, 1'b0, 10'h060, 64'd0);
        push_men(base + 21, 1'b0, 10'h060, 64'd0);
        push_men(base + 26, 1'b0, 10'h021, 64'd0);
        push_ack(1'b1, 64'hD0D0D0D0_E1E1E1E1, base + 4);
        push_ack(1'b1, 64'hD0D0D0D0_E1E1E1E1, base + 9);
        push_ack(1'b0, 64'h00000000_9ABCDEF0, base + 14);
        push_ack(1'b1, 64'hD0D0D0D0_E1E1E1E1, base + 19);
        push_ack(1'b1, 64'hD0D0D0D0_E1E1E1E1, base + 24);
        push_ack(1'b0, 64'h00000000_9ABCDEF0, base + 29);
        fork
            run_d(1'b0, 64'h300, 64'h300, 64'd0, 4);
            run_i(64'h108, 2);
        join
        @(posedge tb_clk); #1;

        // 6: back-to-back loads; second address carries high bits that must wrap
        base = cyc;
        push_men(base + 1, 1'b0, 10'h001, 64'd0);
        push_men(base + 6, 1'b0, 10'h002, 64'd0);
        push_ack(1'b1, 64'h01010101_01010101, base + 4);
        push_ack(1'b1, 64'h02020202_02020202, base + 9);
        run_d(1'b0, 64'h8, 64'hFFFF0000_00000010, 64'd0, 2);

        repeat (4) @(posedge tb_clk);
        @(negedge tb_clk);
        chk("men_q_drained", 64'(men_q.size()), 64'd0);
        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
